tlb_op_ctrl: RTL

Sequencer for the CP0 TLB maintenance instructions TLBP, TLBR, TLBWI and TLBWR. It sits between the CP0/exception stage and the TLB array. It accepts one operation at a time over a valid/ready handshake, drives the TLB write-enable and index, and captures probe and read results into registered CP0 write-back strobes. It also owns the architectural Random and Wired registers, and requests a pipeline flush after any TLB write so that registered translations in the lookup ports cannot be reused stale.

---
 rtl/tlb_op_ctrl_if.sv | 11 +
 rtl/tlb_op_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/tlb_op_ctrl_if.sv
// Operation handshake between the CP0/exception stage (master) and the TLB op sequencer (slave).
interface tlb_op_ctrl_if;
  logic       op_valid;
  logic [1:0] op;
  logic       op_ready;
  logic       done;
  logic       flush_o;

  modport master (output op_valid, op, input op_ready, done, flush_o);
  modport slave  (input op_valid, op, output op_ready, done, flush_o);
endinterface

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBP/TLBR/TLBWI/TLBWR: drives the TLB array, captures results into CP0
// write-back strobes, and owns the architectural Random and Wired registers.
module tlb_op_ctrl #(
  parameter int TLB_NUM  = 32,
  parameter int IDX_BITS = $clog2(TLB_NUM)
) (
  input  logic                clk,
  input  logic                rst,
  tlb_op_ctrl_if.slave        op_bus,
  input  logic [IDX_BITS-1:0] cp0_index_i,
  input  logic                wired_we,
  input  logic [IDX_BITS-1:0] wired_wdata,
  output logic [IDX_BITS-1:0] wired_o,
  output logic [IDX_BITS-1:0] random_o,
  output logic                tlb_we,
  output logic [IDX_BITS-1:0] tlb_index,
  input  logic [31:0]         tlb_probe_i,
  input  logic [11:0]         tlb_mask_i,
  input  logic [31:0]         tlb_entryhi_i,
  input  logic [31:0]         tlb_entrylo0_i,
  input  logic [31:0]         tlb_entrylo1_i,
  output logic                cp0_index_we,
  output logic [31:0]         cp0_index_wdata,
  output logic                cp0_read_we,
  output logic [11:0]         cp0_mask_wdata,
  output logic [31:0]         cp0_entryhi_wdata,
  output logic [31:0]         cp0_entrylo0_wdata,
  output logic [31:0]         cp0_entrylo1_wdata
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [1:0] OP_TLBP  = 2'd0;
  localparam logic [1:0] OP_TLBR  = 2'd1;
  localparam logic [1:0] OP_TLBWR = 2'd3;
  localparam logic [IDX_BITS-1:0] MAX_IDX = IDX_BITS'(TLB_NUM - 1);

  state_t state, next_state;

  logic [1:0]          op_q;
  logic [IDX_BITS-1:0] idx_q;
  logic [IDX_BITS-1:0] random_q;
  logic [IDX_BITS-1:0] wired_q;
  logic                done_q;
  logic                flush_q;

  logic accept;
  logic tlb_we_d;
  logic done_d;
  logic flush_d;
  logic index_we_d;
  logic read_we_d;
  logic capture_probe;
  logic capture_read;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Strobe values computed here are registered so every strobe is glitch-free at the CP0/TLB side.
  always_comb begin
    next_state    = state;
    accept        = 1'b0;
    tlb_we_d      = 1'b0;
    done_d        = 1'b0;
    flush_d       = 1'b0;
    index_we_d    = 1'b0;
    read_we_d     = 1'b0;
    capture_probe = 1'b0;
    capture_read  = 1'b0;
    case (state)
      IDLE: begin
        if (op_bus.op_valid) begin
          accept     = 1'b1;
          tlb_we_d   = op_bus.op[1];
          next_state = EXEC;
        end
      end
      EXEC: begin
        done_d        = 1'b1;
        flush_d       = op_q[1];
        index_we_d    = (op_q == OP_TLBP);
        read_we_d     = (op_q == OP_TLBR);
        capture_probe = (op_q == OP_TLBP);
        capture_read  = (op_q == OP_TLBR);
        next_state    = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q               <= 2'd0;
      idx_q              <= '0;
      tlb_we             <= 1'b0;
      done_q             <= 1'b0;
      flush_q            <= 1'b0;
      cp0_index_we       <= 1'b0;
      cp0_read_we        <= 1'b0;
      cp0_index_wdata    <= 32'd0;
      cp0_mask_wdata     <= 12'd0;
      cp0_entryhi_wdata  <= 32'd0;
      cp0_entrylo0_wdata <= 32'd0;
      cp0_entrylo1_wdata <= 32'd0;
    end else begin
      tlb_we       <= tlb_we_d;
      done_q       <= done_d;
      flush_q      <= flush_d;
      cp0_index_we <= index_we_d;
      cp0_read_we  <= read_we_d;
      // TLBWR samples Random before any simultaneous Wired write resets it.
      if (accept) begin
        op_q  <= op_bus.op;
        idx_q <= (op_bus.op == OP_TLBWR) ? random_q : cp0_index_i;
      end
      if (capture_probe) cp0_index_wdata <= tlb_probe_i;
      if (capture_read) begin
        cp0_mask_wdata     <= tlb_mask_i;
        cp0_entryhi_wdata  <= tlb_entryhi_i;
        cp0_entrylo0_wdata <= tlb_entrylo0_i;
        cp0_entrylo1_wdata <= tlb_entrylo1_i;
      end
    end
  end

  // Random walks down from the top entry to Wired and wraps, so wired entries are never replaced.
  always_ff @(posedge clk) begin
    if (rst) begin
      random_q <= MAX_IDX;
      wired_q  <= '0;
    end else begin
      if (wired_we) wired_q <= wired_wdata;
      if (wired_we || (random_q == wired_q)) random_q <= MAX_IDX;
      else                                   random_q <= random_q - 1'b1;
    end
  end

  assign op_bus.op_ready = (state == IDLE);
  assign op_bus.done     = done_q;
  assign op_bus.flush_o  = flush_q;
  assign tlb_index       = idx_q;
  assign random_o        = random_q;
  assign wired_o         = wired_q;

endmodule
